// File: rtl/ndp_buf_pkg.sv
// Shared constants and read-side state type for the NDP weight ping-pong buffer.
package ndp_buf_pkg;

    localparam int NDP_A_WIDTH = 32;
    localparam int NDP_B_WIDTH = 2 * NDP_A_WIDTH;
    localparam int NDP_LINES   = 16;
    localparam int NDP_ADDRA_W = $clog2(4 * NDP_LINES);
    localparam int NDP_ADDRB_W = $clog2(2 * NDP_LINES);

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } rd_state_t;

endpackage

// File: rtl/ndp_skid_fifo.sv
// Two-entry FIFO holding BRAM read lines (plus last tag) in front of the NDP port.
module ndp_skid_fifo
    import ndp_buf_pkg::*;
#(
    parameter int WIDTH = NDP_B_WIDTH + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occupancy
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_push;

    assign o_valid     = (r_count != 2'd0);
    assign o_occupancy = r_count;
    assign w_pop       = o_valid & i_ready;
    assign w_push      = i_push & ((r_count != 2'd2) | w_pop);
    assign o_data      = o_valid ? r_mem[r_rptr] : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/weight_pingpong_ctrl.sv
// Packs a 32-bit weight stream into two 64-bit BRAM banks and streams full banks
// out over valid/ready while the other bank fills.
module weight_pingpong_ctrl
    import ndp_buf_pkg::*;
#(
    parameter int A_WIDTH = NDP_A_WIDTH,
    parameter int B_WIDTH = 2 * A_WIDTH,
    parameter int LINES   = NDP_LINES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [B_WIDTH-1:0]         out_data,
    output logic                       out_last,
    output logic [1:0]                 bank_full,
    output logic                       bram_ena,
    output logic                       bram_wea,
    output logic [$clog2(4*LINES)-1:0] bram_addra,
    output logic [A_WIDTH-1:0]         bram_dina,
    output logic                       bram_enb,
    output logic [$clog2(2*LINES)-1:0] bram_addrb,
    input  logic [B_WIDTH-1:0]         bram_doutb
);

    localparam int WC_W = $clog2(2 * LINES);
    localparam int RC_W = $clog2(LINES);

    logic              r_wr_bank;
    logic [WC_W-1:0]   r_wr_cnt;
    logic [1:0]        r_full;
    rd_state_t         r_state;
    logic              r_rd_bank;
    logic [RC_W-1:0]   r_rd_cnt;
    logic              r_rd_vld_p1;
    logic              r_rd_last_p1;

    logic              w_wr_hs;
    logic              w_wr_wrap;
    logic [1:0]        w_full_set;
    logic [1:0]        w_full_clr;
    logic [1:0]        w_occ;
    logic              w_pop;
    logic              w_rd_credit;
    logic              w_rd_issue;
    logic              w_rd_last;
    logic              w_rd_done;
    logic [B_WIDTH:0]  w_fifo_dout;

    // Write side: the word goes straight to port A on the handshake edge.
    assign in_ready   = ~r_full[r_wr_bank];
    assign w_wr_hs    = reset & in_valid & in_ready;
    assign w_wr_wrap  = w_wr_hs & (r_wr_cnt == WC_W'(2 * LINES - 1));
    assign bram_ena   = w_wr_hs;
    assign bram_wea   = w_wr_hs;
    assign bram_addra = w_wr_hs ? {r_wr_bank, r_wr_cnt} : '0;
    assign bram_dina  = w_wr_hs ? in_data : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
        end else if (w_wr_hs) begin
            if (w_wr_wrap) begin
                r_wr_cnt  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_cnt <= r_wr_cnt + WC_W'(1);
            end
        end
    end

    // Writer only sets a non-full bank, reader only clears a full one, so both may land together.
    assign w_full_set = w_wr_wrap ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_full_clr = w_rd_done ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign bank_full  = r_full;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
        end
    end

    // Read side, stage p0: issue; a line being popped this cycle already counts as a free slot.
    assign w_pop       = out_valid & out_ready;
    assign w_rd_credit = ({1'b0, w_occ} + {2'b00, r_rd_vld_p1}) < (3'd2 + {2'b00, w_pop});
    assign w_rd_issue  = reset & w_rd_credit & ((r_state == R_STREAM) | r_full[r_rd_bank]);
    assign w_rd_last   = (r_rd_cnt == RC_W'(LINES - 1));
    assign w_rd_done   = w_rd_issue & w_rd_last;
    assign bram_enb    = w_rd_issue;
    assign bram_addrb  = w_rd_issue ? {r_rd_bank, r_rd_cnt} : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= R_IDLE;
            r_rd_bank    <= 1'b0;
            r_rd_cnt     <= '0;
            r_rd_vld_p1  <= 1'b0;
            r_rd_last_p1 <= 1'b0;
        end else begin
            r_rd_vld_p1  <= w_rd_issue;
            r_rd_last_p1 <= w_rd_done;
            case (r_state)
                R_IDLE:   if (r_full[r_rd_bank]) r_state <= R_STREAM;
                R_STREAM: r_state <= R_STREAM;
            endcase
            if (w_rd_issue) begin
                if (w_rd_last) begin
                    r_rd_cnt  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                    r_state   <= R_IDLE;
                end else begin
                    r_rd_cnt <= r_rd_cnt + RC_W'(1);
                end
            end
        end
    end

    // Stage p1: BRAM data is valid, captured into the output FIFO at the next edge.
    ndp_skid_fifo #(
        .WIDTH(B_WIDTH + 1)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_push      (r_rd_vld_p1),
        .i_data      ({r_rd_last_p1, bram_doutb}),
        .o_valid     (out_valid),
        .i_ready     (out_ready),
        .o_data      (w_fifo_dout),
        .o_occupancy (w_occ)
    );

    assign out_data = w_fifo_dout[B_WIDTH-1:0];
    assign out_last = w_fifo_dout[B_WIDTH];

endmodule
